// File: rtl/clock_enable_ctrl.sv
// Per-channel clock-enable controller: gates idle domains and restarts them on request.
// Optional per-channel gated-cycle statistics are enabled with CLK_EN_CTRL_STATS_EN.
module clock_enable_ctrl #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned IDLE_CYCLES = 16,
   parameter int unsigned WAKE_CYCLES = 2
) (
   input  logic                   sys_clk_i,
   input  logic                   sys_reset_i,
   input  logic [NUM_CH-1:0]      activity_i,
   input  logic [NUM_CH-1:0]      wake_req_i,
   input  logic                   force_on_i,
`ifdef CLK_EN_CTRL_STATS_EN
   input  logic                   stats_clr_i,
   output logic [16*NUM_CH-1:0]   gated_cnt_o,
`endif
   output logic [NUM_CH-1:0]      enable_o,
   output logic [NUM_CH-1:0]      ready_o,
   output logic [NUM_CH-1:0]      gated_o
);

   localparam int unsigned MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
   localparam int unsigned CW      = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {
      ST_ON    = 2'd0,
      ST_DRAIN = 2'd1,
      ST_OFF   = 2'd2,
      ST_WAKE  = 2'd3
   } state_t;

   state_t              state_q [NUM_CH];
   state_t              state_d [NUM_CH];
   logic [CW-1:0]       cnt_q   [NUM_CH];
   logic [CW-1:0]       cnt_d   [NUM_CH];
   logic [NUM_CH-1:0]   busy;
   logic [NUM_CH-1:0]   wake;
   logic [NUM_CH-1:0]   en_d;
   logic [NUM_CH-1:0]   rdy_d;
   logic [NUM_CH-1:0]   gated_d;

   assign busy = activity_i | wake_req_i | {NUM_CH{force_on_i}};
   assign wake = wake_req_i | {NUM_CH{force_on_i}};

   // State and counter registers; reset forces every channel to ON.
   always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
      if (sys_reset_i) begin
         for (int n = 0; n < NUM_CH; n++) begin
            state_q[n] <= ST_ON;
            cnt_q[n]   <= '0;
         end
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            state_q[n] <= state_d[n];
            cnt_q[n]   <= cnt_d[n];
         end
      end
   end

   // Next-state logic and Moore output decode of the next state.
   always_comb begin
      en_d    = '0;
      rdy_d   = '0;
      gated_d = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         state_d[n] = state_q[n];
         cnt_d[n]   = cnt_q[n];
         unique case (state_q[n])
            ST_ON: begin
               if (busy[n]) begin
                  cnt_d[n] = '0;
               end else if (cnt_q[n] == CW'(IDLE_CYCLES - 1)) begin
                  state_d[n] = ST_DRAIN;
                  cnt_d[n]   = '0;
               end else begin
                  cnt_d[n] = cnt_q[n] + CW'(1);
               end
            end
            ST_DRAIN: begin
               cnt_d[n]   = '0;
               state_d[n] = busy[n] ? ST_ON : ST_OFF;
            end
            ST_OFF: begin
               if (wake[n]) begin
                  state_d[n] = ST_WAKE;
                  cnt_d[n]   = '0;
               end
            end
            ST_WAKE: begin
               if (cnt_q[n] == CW'(WAKE_CYCLES - 1)) begin
                  state_d[n] = ST_ON;
                  cnt_d[n]   = '0;
               end else begin
                  cnt_d[n] = cnt_q[n] + CW'(1);
               end
            end
            default: begin
               state_d[n] = ST_ON;
               cnt_d[n]   = '0;
            end
         endcase
         en_d[n]    = (state_d[n] != ST_OFF);
         rdy_d[n]   = (state_d[n] == ST_ON);
         gated_d[n] = (state_d[n] == ST_OFF);
      end
   end

   // Output flops keep the gate-cell enables glitch-free.
   always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
      if (sys_reset_i) begin
         enable_o <= '1;
         ready_o  <= '1;
         gated_o  <= '0;
      end else begin
         enable_o <= en_d;
         ready_o  <= rdy_d;
         gated_o  <= gated_d;
      end
   end

`ifdef CLK_EN_CTRL_STATS_EN
   // Saturating count of cycles spent in OFF; clear wins over increment.
   always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
      if (sys_reset_i) begin
         gated_cnt_o <= '0;
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (stats_clr_i) begin
               gated_cnt_o[16*n +: 16] <= '0;
            end else if ((state_q[n] == ST_OFF) && (gated_cnt_o[16*n +: 16] != 16'hFFFF)) begin
               gated_cnt_o[16*n +: 16] <= gated_cnt_o[16*n +: 16] + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_clock_enable_ctrl.sv
// Bench for clock_enable_ctrl: directed scenarios plus random traffic against an
// idle-run/wake-countdown reference model. Stats checks run when CLK_EN_CTRL_STATS_EN is set.
module tb_clock_enable_ctrl;

   localparam int unsigned NUM_CH      = 4;
   localparam int unsigned IDLE_CYCLES = 16;
   localparam int unsigned WAKE_CYCLES = 2;

   logic              sys_clk_i   = 1'b0;
   logic              sys_reset_i = 1'b1;
   logic [NUM_CH-1:0] activity_i  = '0;
   logic [NUM_CH-1:0] wake_req_i  = '0;
   logic              force_on_i  = 1'b0;
   logic [NUM_CH-1:0] enable_o;
   logic [NUM_CH-1:0] ready_o;
   logic [NUM_CH-1:0] gated_o;
`ifdef CLK_EN_CTRL_STATS_EN
   logic                 stats_clr_i = 1'b0;
   logic [16*NUM_CH-1:0] gated_cnt_o;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model: consecutive idle samples while enabled, OFF flag, wake countdown.
   int                idle_run  [NUM_CH];
   bit                m_off     [NUM_CH];
   int                wake_left [NUM_CH];
   int                m_gcnt    [NUM_CH];
   logic [NUM_CH-1:0] exp_en;
   logic [NUM_CH-1:0] exp_rdy;
   logic [NUM_CH-1:0] exp_gated;

   clock_enable_ctrl #(
      .NUM_CH      (NUM_CH),
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES)
   ) dut (
      .sys_clk_i   (sys_clk_i),
      .sys_reset_i (sys_reset_i),
      .activity_i  (activity_i),
      .wake_req_i  (wake_req_i),
      .force_on_i  (force_on_i),
`ifdef CLK_EN_CTRL_STATS_EN
      .stats_clr_i (stats_clr_i),
      .gated_cnt_o (gated_cnt_o),
`endif
      .enable_o    (enable_o),
      .ready_o     (ready_o),
      .gated_o     (gated_o)
   );

   always #5 sys_clk_i = ~sys_clk_i;

   function automatic void model_expect();
      for (int n = 0; n < NUM_CH; n++) begin
         exp_en[n]    = !m_off[n];
         exp_gated[n] = m_off[n];
         exp_rdy[n]   = !m_off[n] && (wake_left[n] == 0) && (idle_run[n] != int'(IDLE_CYCLES));
      end
   endfunction

   function automatic void model_reset();
      for (int n = 0; n < NUM_CH; n++) begin
         idle_run[n]  = 0;
         m_off[n]     = 1'b0;
         wake_left[n] = 0;
         m_gcnt[n]    = 0;
      end
      model_expect();
   endfunction

   // Advance one clock edge, applying the inputs present at that edge to the model.
   task automatic step();
      bit b;
      bit w;
      @(posedge sys_clk_i);
      for (int n = 0; n < NUM_CH; n++) begin
         b = activity_i[n] | wake_req_i[n] | force_on_i;
         w = wake_req_i[n] | force_on_i;
`ifdef CLK_EN_CTRL_STATS_EN
         if (stats_clr_i) m_gcnt[n] = 0;
         else if (m_off[n] && m_gcnt[n] < 65535) m_gcnt[n]++;
`endif
         if (m_off[n]) begin
            if (w) begin
               m_off[n]     = 1'b0;
               wake_left[n] = int'(WAKE_CYCLES);
            end
         end else if (wake_left[n] > 0) begin
            wake_left[n]--;
            if (wake_left[n] == 0) idle_run[n] = 0;
         end else if (b) begin
            idle_run[n] = 0;
         end else begin
            idle_run[n]++;
            if (idle_run[n] == int'(IDLE_CYCLES) + 1) begin
               m_off[n]    = 1'b1;
               idle_run[n] = 0;
            end
         end
      end
      model_expect();
      #1;
   endtask

   task automatic apply_reset();
      activity_i  = '0;
      wake_req_i  = '0;
      force_on_i  = 1'b0;
      sys_reset_i = 1'b1;
      model_reset();
      repeat (2) @(posedge sys_clk_i);
      #2 sys_reset_i = 1'b0;
   endtask

   task automatic test_reset();
      sys_reset_i = 1'b1;
      model_reset();
      repeat (3) @(posedge sys_clk_i);
      #1;
      checks++;
      if ({enable_o, ready_o, gated_o} !== {4'hF, 4'hF, 4'h0}) begin
         failures++;
         $display("FAIL reset_hold: en=%h rdy=%h gated=%h expected en=f rdy=f gated=0", enable_o, ready_o, gated_o);
      end
      #1 sys_reset_i = 1'b0;
      #1;
      checks++;
      if ({enable_o, ready_o, gated_o} !== {4'hF, 4'hF, 4'h0}) begin
         failures++;
         $display("FAIL reset_release: en=%h rdy=%h gated=%h expected en=f rdy=f gated=0", enable_o, ready_o, gated_o);
      end
   endtask

   task automatic test_gating();
      apply_reset();
      for (int i = 1; i <= 17; i++) begin
         step();
         checks++;
         if ({enable_o, ready_o, gated_o} !== {exp_en, exp_rdy, exp_gated}) begin
            failures++;
            $display("FAIL gating_edge%0d: en=%h rdy=%h gated=%h expected en=%h rdy=%h gated=%h", i, enable_o, ready_o, gated_o, exp_en, exp_rdy, exp_gated);
         end
         if (i == 16) begin
            checks++;
            if ({enable_o[0], ready_o[0]} !== 2'b10) begin
               failures++;
               $display("FAIL gating_drain: en0=%b rdy0=%b expected en0=1 rdy0=0", enable_o[0], ready_o[0]);
            end
         end
         if (i == 17) begin
            checks++;
            if ({enable_o[0], gated_o[0]} !== 2'b01) begin
               failures++;
               $display("FAIL gating_off: en0=%b gated0=%b expected en0=0 gated0=1", enable_o[0], gated_o[0]);
            end
         end
      end
   endtask

   task automatic test_wake();
      wake_req_i = 4'b0100;
      step();
      wake_req_i = '0;
      checks++;
      if ({enable_o, ready_o, gated_o} !== {4'b0100, 4'b0000, 4'b1011}) begin
         failures++;
         $display("FAIL wake_edge: en=%h rdy=%h gated=%h expected en=4 rdy=0 gated=b", enable_o, ready_o, gated_o);
      end
      step();
      checks++;
      if (ready_o[2] !== 1'b0) begin
         failures++;
         $display("FAIL wake_early: rdy2=%b expected 0", ready_o[2]);
      end
      step();
      checks++;
      if ({enable_o, ready_o, gated_o} !== {4'b0100, 4'b0100, 4'b1011}) begin
         failures++;
         $display("FAIL wake_ready: en=%h rdy=%h gated=%h expected en=4 rdy=4 gated=b", enable_o, ready_o, gated_o);
      end
   endtask

   // Pulse activity[1] with 'gap' idle cycles between pulses.
   task automatic test_activity_gap(input int gap, input bit expect_drain);
      bit saw_drain = 1'b0;
      bit en_drop   = 1'b0;
      apply_reset();
      for (int p = 0; p < 5; p++) begin
         activity_i = 4'b0010;
         for (int i = 0; i <= gap; i++) begin
            step();
            activity_i = '0;
            if (ready_o[1] === 1'b0) saw_drain = 1'b1;
            if (enable_o[1] !== 1'b1) en_drop = 1'b1;
            checks++;
            if ({enable_o, ready_o, gated_o} !== {exp_en, exp_rdy, exp_gated}) begin
               failures++;
               $display("FAIL activity_gap%0d: en=%h rdy=%h gated=%h expected en=%h rdy=%h gated=%h", gap, enable_o, ready_o, gated_o, exp_en, exp_rdy, exp_gated);
            end
         end
      end
      checks++;
      if ({saw_drain, en_drop} !== {expect_drain, 1'b0}) begin
         failures++;
         $display("FAIL activity_gap%0d_summary: drain_seen=%b en_dropped=%b expected drain_seen=%b en_dropped=0", gap, saw_drain, en_drop, expect_drain);
      end
   endtask

   task automatic test_force();
      apply_reset();
      repeat (17) step();
      checks++;
      if (gated_o !== 4'hF) begin
         failures++;
         $display("FAIL force_setup: gated=%h expected f", gated_o);
      end
      force_on_i = 1'b1;
      step();
      force_on_i = 1'b0;
      checks++;
      if ({enable_o, ready_o, gated_o} !== {4'hF, 4'h0, 4'h0}) begin
         failures++;
         $display("FAIL force_edge: en=%h rdy=%h gated=%h expected en=f rdy=0 gated=0", enable_o, ready_o, gated_o);
      end
      repeat (WAKE_CYCLES) step();
      checks++;
      if ({enable_o, ready_o, gated_o} !== {4'hF, 4'hF, 4'h0}) begin
         failures++;
         $display("FAIL force_ready: en=%h rdy=%h gated=%h expected en=f rdy=f gated=0", enable_o, ready_o, gated_o);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      repeat (17) step();
      wake_req_i = 4'b0001;
      step();
      wake_req_i = '0;
      checks++;
      if ({enable_o, ready_o, gated_o} !== {4'b0001, 4'b0000, 4'b1110}) begin
         failures++;
         $display("FAIL async_setup: en=%h rdy=%h gated=%h expected en=1 rdy=0 gated=e", enable_o, ready_o, gated_o);
      end
      #2 sys_reset_i = 1'b1;
      #1;
      checks++;
      if ({enable_o, ready_o, gated_o} !== {4'hF, 4'hF, 4'h0}) begin
         failures++;
         $display("FAIL async_reset: en=%h rdy=%h gated=%h expected en=f rdy=f gated=0", enable_o, ready_o, gated_o);
      end
      model_reset();
      @(posedge sys_clk_i);
      #2 sys_reset_i = 1'b0;
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         for (int n = 0; n < NUM_CH; n++) begin
            activity_i[n] = ($urandom_range(0, 19) == 0);
            wake_req_i[n] = ($urandom_range(0, 39) == 0);
         end
         force_on_i = ($urandom_range(0, 299) == 0);
         step();
         checks++;
         if ({enable_o, ready_o, gated_o} !== {exp_en, exp_rdy, exp_gated}) begin
            failures++;
            $display("FAIL random_cyc%0d: en=%h rdy=%h gated=%h expected en=%h rdy=%h gated=%h", i, enable_o, ready_o, gated_o, exp_en, exp_rdy, exp_gated);
         end
      end
      activity_i = '0;
      wake_req_i = '0;
      force_on_i = 1'b0;
   endtask

`ifdef CLK_EN_CTRL_STATS_EN
   task automatic test_stats();
      logic [16*NUM_CH-1:0] exp_cnt;
      apply_reset();
      repeat (17) step();
      repeat (70000) step();
      for (int n = 0; n < NUM_CH; n++) exp_cnt[16*n +: 16] = 16'(m_gcnt[n]);
      checks++;
      if (gated_cnt_o[15:0] !== 16'hFFFF || gated_cnt_o !== exp_cnt) begin
         failures++;
         $display("FAIL stats_saturate: cnt=%h expected %h", gated_cnt_o, exp_cnt);
      end
      stats_clr_i = 1'b1;
      step();
      stats_clr_i = 1'b0;
      checks++;
      if (gated_cnt_o !== '0) begin
         failures++;
         $display("FAIL stats_clear: cnt=%h expected 0", gated_cnt_o);
      end
      step();
      for (int n = 0; n < NUM_CH; n++) exp_cnt[16*n +: 16] = 16'(m_gcnt[n]);
      checks++;
      if (gated_cnt_o !== exp_cnt) begin
         failures++;
         $display("FAIL stats_resume: cnt=%h expected %h", gated_cnt_o, exp_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_gating();
      test_wake();
      test_activity_gap(15, 1'b0);
      test_activity_gap(16, 1'b1);
      test_force();
      test_async_reset();
      test_random();
`ifdef CLK_EN_CTRL_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
